div_scheduler: RTL and testbench
================================

Name: div_scheduler

Overview:
- Upstream operand scheduler for the fixed-point iterative divider.
- Queues (a, b) division requests from navigation datapath producers in a small FIFO.
- Presents one request at a time to the divider, restarts it with its active-high synchronous reset, and waits for its sticky complete flag.
- Returns quotients in request order over a valid/ready result port, and short-circuits divide-by-zero without running the divider.

Parameters:
- DATA_WIDTH, 16, operand/quotient width; must equal the divider's DATA_WIDTH.
- BIN_POS, 8, binary point position; informational, passed through to the divider instance by the parent.
- FIFO_DEPTH, 4, request FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  FIFO can accept a request
- req_a  in  DATA_WIDTH  dividend, two's complement fixed point
- req_b  in  DATA_WIDTH  divisor, two's complement fixed point
- res_valid  out  1  result held on res_q/res_err
- res_ready  in  1  consumer accepts the result
- res_q  out  DATA_WIDTH  quotient
- res_err  out  1  divisor was zero (or timeout, see feature)
- div_rst  out  1  active-high synchronous restart to the divider
- div_a  out  DATA_WIDTH  divider operand a, held stable for the whole operation
- div_b  out  DATA_WIDTH  divider operand b, held stable for the whole operation
- div_complete  in  1  divider complete flag
- div_out  in  DATA_WIDTH  divider result
- div_zero  in  1  divider b==0 flag; monitored only, not used for control
- busy  out  1  state is not IDLE or FIFO is non-empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset (rst low, asynchronous):
  - state IDLE; FIFO emptied, fifo_count=0.
  - req_ready=1, res_valid=0, res_q=0, res_err=0.
  - div_rst=1, div_a=0, div_b=0, busy=0.
  - Applies mid-operation: any in-flight request and any held result are discarded.
- FIFO:
  - Push on an edge with req_valid&&req_ready.
  - req_ready=(fifo_count<FIFO_DEPTH), registered; it does not look ahead to a same-cycle pop.
  - Push and pop on the same edge leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - A push while full is impossible by construction; req_valid is ignored when req_ready=0.
- States:
  - IDLE: div_rst=1. If FIFO non-empty, pop head into div_a/div_b. Next state is ZERO if head b==0, else LOAD.
  - LOAD: exactly 1 cycle. div_rst=1 so the divider clears count, quotient and complete. Next state RUN.
  - RUN: div_rst=0, divider iterates. On the first edge where div_complete=1: res_q<=div_out, res_err<=0, res_valid<=1, next state HOLD.
  - ZERO: 1 cycle. res_q<=0, res_err<=1, res_valid<=1, next state HOLD. div_rst stays 1 and the divider never runs.
  - HOLD: div_rst=1; res_valid, res_q and res_err are held stable. On an edge with res_ready=1, res_valid<=0 and next state IDLE.
- Pipelining: one request in flight. Further requests queue in the FIFO, giving FIFO_DEPTH+1 outstanding in total. Results return strictly in request order.
- Latency, idle with empty FIFO, request pushed at edge N:
  - Nonzero divisor: pop at N+1, LOAD at N+2, divider iterates N+3..N+2+2*DATA_WIDTH, res_valid=1 after edge N+3+2*DATA_WIDTH.
  - Zero divisor: res_valid=1 after edge N+2.
- div_rst is held high everywhere except RUN, so divider complete is never stale at RUN entry.
- Minimum gap between results is one IDLE bubble after the HOLD handshake.
- Signedness and width handling are the divider's; res_q is div_out passed through unmodified.

Optional Feature:
- Macro: DIV_SCHED_TIMEOUT_EN.
- Defined:
  - A watchdog counter of $clog2(2*DATA_WIDTH+8) bits clears on LOAD and increments each cycle in RUN.
  - If it reaches 2*DATA_WIDTH+4 with div_complete=0: res_q<=0, res_err<=1, res_valid<=1, state HOLD, div_rst forced 1 from the following cycle.
- Undefined: no counter; RUN waits indefinitely for div_complete.

Test Plan (DATA_WIDTH=16, BIN_POS=8, real divider instance attached):
- Single request a=0x0600 (6.0), b=0x0200 (2.0) pushed at edge N -> res_q=0x0300, res_err=0, res_valid rises after edge N+35 and holds until res_ready.
- Signed request a=0xFA00 (-6.0), b=0x0200 -> res_q=0xFD00. Follow with a=0x0100, b=0xFC00 (-4.0) -> res_q=0xFFC0.
- Divide by zero a=0x1234, b=0x0000 -> res_q=0, res_err=1, res_valid after edge N+2, div_rst never deasserted.
- Backpressure: res_ready=0, push 6 requests back-to-back -> 5 accepted, req_ready=0 with fifo_count=4. Release res_ready -> 5 results in order, req_ready returns 1 one edge after the first pop.
- Reset mid-RUN: drop rst 10 cycles into a division -> immediately res_valid=0, fifo_count=0, div_rst=1. After release, a new request completes correctly.
- With DIV_SCHED_TIMEOUT_EN defined and div_complete tied 0 -> res_err=1, res_q=0 after 36 RUN cycles. Without the macro -> res_valid stays 0.

Source files
------------

// File: rtl/div_scheduler.sv
// Operand scheduler in front of the fixed-point iterative divider; queues (a, b) requests and returns quotients in order.
// Latency: nonzero divisor, result valid 3+2*DATA_WIDTH edges after the push edge; zero divisor, 2 edges after it.
// Backpressure: req_ready drops when the FIFO holds FIFO_DEPTH entries; a result is held in HOLD until res_ready.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready request handshake; req_a/req_b dividend and divisor
//   res_valid/res_ready result handshake; res_q quotient, res_err divisor was zero (or watchdog expired)
//   div_rst/div_a/div_b restart and operands driven to the divider
//   div_complete/div_out/div_zero  divider status and result
//   busy, fifo_count    status: activity flag and number of queued requests
//
// Optional feature: define DIV_SCHED_TIMEOUT_EN to add a RUN-state watchdog that
// ends a division with res_err=1 after 2*DATA_WIDTH+4 cycles without div_complete.

module div_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int BIN_POS    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [DATA_WIDTH-1:0]         req_a,
  input  logic [DATA_WIDTH-1:0]         req_b,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [DATA_WIDTH-1:0]         res_q,
  output logic                          res_err,
  output logic                          div_rst,
  output logic [DATA_WIDTH-1:0]         div_a,
  output logic [DATA_WIDTH-1:0]         div_b,
  input  logic                          div_complete,
  input  logic [DATA_WIDTH-1:0]         div_out,
  input  logic                          div_zero,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // BIN_POS only matters to the divider; it is range-checked here so a bad
  // parent configuration fails at elaboration rather than in silicon.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      BIN_POS < 0 || BIN_POS >= DATA_WIDTH) begin : g_bad_cfg
    $error("div_scheduler: unsupported parameter set");
  end

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } req_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_ZERO = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  req_t             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_req_ready;

  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;
  req_t             w_head;

  assign w_push = req_valid && r_req_ready;
  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{a: req_a, b: req_b};
    end
  end

  // req_ready is registered from the next count, so it always equals
  // fifo_count < FIFO_DEPTH and never admits a push into a full FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_req_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count     <= w_count_nxt;
      r_req_ready <= (w_count_nxt < CNT_W'(FIFO_DEPTH));
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_nxt;
  logic   w_done;
  logic   w_zero;
  logic   w_timeout;
  logic   w_release;

`ifdef DIV_SCHED_TIMEOUT_EN
  localparam int              WD_W    = $clog2(2 * DATA_WIDTH + 8);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(2 * DATA_WIDTH + 3);
  logic [WD_W-1:0] r_wdog;

  // Counts RUN cycles; the division is abandoned on the (2*DATA_WIDTH+4)th.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog <= '0;
    end else if (r_state == S_LOAD) begin
      r_wdog <= '0;
    end else if (r_state == S_RUN) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    w_zero      = 1'b0;
    w_timeout   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          // Zero divisors never reach the divider.
          w_state_nxt = (w_head.b == '0) ? S_ZERO : S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (div_complete) begin
          w_done      = 1'b1;
          w_state_nxt = S_HOLD;
        end
`ifdef DIV_SCHED_TIMEOUT_EN
        else if (r_wdog == WD_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_HOLD;
        end
`endif
      end
      S_ZERO: begin
        w_zero      = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (res_ready) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Divider interface and result registers
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_div_a;
  logic [DATA_WIDTH-1:0] r_div_b;
  logic                  r_div_rst;
  logic                  r_res_vld;
  logic [DATA_WIDTH-1:0] r_res_q;
  logic                  r_res_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_a   <= '0;
      r_div_b   <= '0;
      r_div_rst <= 1'b1;
      r_res_vld <= 1'b0;
      r_res_q   <= '0;
      r_res_err <= 1'b0;
    end else begin
      // Divider is released only while in RUN, so it always enters RUN freshly
      // cleared and its sticky complete flag can never be stale.
      r_div_rst <= (w_state_nxt != S_RUN);
      if (w_pop) begin
        r_div_a <= w_head.a;
        r_div_b <= w_head.b;
      end
      if (w_done) begin
        r_res_q   <= div_out;
        r_res_err <= 1'b0;
        r_res_vld <= 1'b1;
      end else if (w_zero || w_timeout) begin
        r_res_q   <= '0;
        r_res_err <= 1'b1;
        r_res_vld <= 1'b1;
      end else if (w_release) begin
        r_res_vld <= 1'b0;
      end
    end
  end

  // div_zero is status only: a zero divisor is filtered in IDLE, so the
  // divider must never report one while it is running.
  a_no_zero_in_run: assert property (@(posedge clk) disable iff (!rst)
    (r_state == S_RUN) |-> !div_zero);

  assign req_ready  = r_req_ready;
  assign res_valid  = r_res_vld;
  assign res_q      = r_res_q;
  assign res_err    = r_res_err;
  assign div_rst    = r_div_rst;
  assign div_a      = r_div_a;
  assign div_b      = r_div_b;
  assign busy       = (r_state != S_IDLE) || (r_count != '0);
  assign fifo_count = r_count;

endmodule

// File: tb/tb_div_scheduler.sv
// Bench for div_scheduler with a behavioural iterative divider attached.
// Directed vectors with hand-computed quotients (Q8.8 signed fixed point).
// Covers reset, latency, signed division, divide by zero, backpressure, mid-run reset and the watchdog.

module tb_div_scheduler;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [DW-1:0] req_a = '0;
  logic [DW-1:0] req_b = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_q;
  logic          res_err;
  logic          div_rst;
  logic [DW-1:0] div_a;
  logic [DW-1:0] div_b;
  logic          div_complete;
  logic [DW-1:0] div_out;
  logic          div_zero;
  logic          busy;
  logic [2:0]    fifo_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_scheduler #(.DATA_WIDTH(DW), .BIN_POS(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_q(res_q), .res_err(res_err),
    .div_rst(div_rst), .div_a(div_a), .div_b(div_b),
    .div_complete(div_complete), .div_out(div_out), .div_zero(div_zero),
    .busy(busy), .fifo_count(fifo_count)
  );

  // Behavioural divider: cleared by div_rst, 2*DW iteration cycles, sticky complete.
  logic       stall = 1'b0;
  int         m_cnt;
  logic       m_complete;
  logic [DW-1:0] m_q;

  function automatic logic [DW-1:0] fx_div(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int sa, sb, q;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) return '0;
    q = (sa * 256) / sb;
    return q[DW-1:0];
  endfunction

  always @(posedge clk) begin
    if (div_rst) begin
      m_cnt      <= 0;
      m_complete <= 1'b0;
      m_q        <= '0;
    end else if (!m_complete && !stall) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 2 * DW - 1) begin
        m_complete <= 1'b1;
        m_q        <= fx_div(div_a, div_b);
      end
    end
  end

  assign div_complete = m_complete;
  assign div_out      = m_q;
  assign div_zero     = (div_b == '0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    tick();
    req_valid = 1'b0;
  endtask

  // Waits (bounded) for a result, checks it and completes the handshake.
  task automatic get(input string tag, input logic [DW-1:0] q, input logic err);
    int n;
    n = 0;
    while (res_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_vld"}, res_valid, 1);
    chk({tag, "_q"}, res_q, q);
    chk({tag, "_err"}, res_err, err);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_drop"}, res_valid, 0);
  endtask

  logic [DW-1:0] bp_q [5] = '{16'h0080, 16'h0100, 16'h0180, 16'h0200, 16'h0280};

  initial begin
    int n;
    int acc;
    logic rst_seen_low;

    // ---- reset state ----
    #12;
    chk("rst_vld", res_valid, 0);
    chk("rst_q", res_q, 0);
    chk("rst_err", res_err, 0);
    chk("rst_rdy", req_ready, 1);
    chk("rst_divrst", div_rst, 1);
    chk("rst_diva", div_a, 0);
    chk("rst_divb", div_b, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", fifo_count, 0);
    tick();
    rst = 1'b1;
    tick();

    // ---- single request 6.0 / 2.0, latency ----
    push(16'h0600, 16'h0200);           // edge N
    chk("t1_cnt_push", fifo_count, 1);
    chk("t1_busy", busy, 1);
    tick();                              // N+1: popped, LOAD
    chk("t1_cnt_pop", fifo_count, 0);
    chk("t1_diva", div_a, 16'h0600);
    chk("t1_divb", div_b, 16'h0200);
    chk("t1_load_rst", div_rst, 1);
    tick();                              // N+2: RUN
    chk("t1_run_rst", div_rst, 0);
    n = 2;
    while (res_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("t1_latency", n, 35);
    chk("t1_q", res_q, 16'h0300);
    chk("t1_err", res_err, 0);
    repeat (3) tick();
    chk("t1_hold_vld", res_valid, 1);
    chk("t1_hold_q", res_q, 16'h0300);
    chk("t1_hold_rst", div_rst, 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("t1_drop", res_valid, 0);

    // ---- signed division ----
    push(16'hFA00, 16'h0200);
    get("neg6_2", 16'hFD00, 1'b0);
    push(16'h0100, 16'hFC00);
    get("1_neg4", 16'hFFC0, 1'b0);

    // ---- divide by zero ----
    push(16'h1234, 16'h0000);            // edge N
    rst_seen_low = 1'b0;
    tick();                              // N+1: ZERO
    if (div_rst !== 1'b1) rst_seen_low = 1'b1;
    chk("dz_vld_early", res_valid, 0);
    tick();                              // N+2: HOLD
    if (div_rst !== 1'b1) rst_seen_low = 1'b1;
    chk("dz_vld", res_valid, 1);
    chk("dz_q", res_q, 0);
    chk("dz_err", res_err, 1);
    chk("dz_divrst", rst_seen_low, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("dz_drop", res_valid, 0);

    // ---- backpressure: 6 offered, 5 accepted ----
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_a     = DW'((i + 1) << 8);
      req_b     = 16'h0200;
      if (req_ready === 1'b1) acc++;
      tick();
    end
    req_valid = 1'b0;
    chk("bp_accepted", acc, 5);
    chk("bp_rdy_full", req_ready, 0);
    chk("bp_cnt_full", fifo_count, 4);
    n = 0;
    while (res_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("bp_r0_vld", res_valid, 1);
    chk("bp_r0_q", res_q, bp_q[0]);
    chk("bp_r0_rdy", req_ready, 0);
    res_ready = 1'b1;
    tick();                              // HOLD -> IDLE
    res_ready = 1'b0;
    chk("bp_r0_drop", res_valid, 0);
    chk("bp_cnt_before_pop", fifo_count, 4);
    tick();                              // IDLE pops next request
    chk("bp_cnt_after_pop", fifo_count, 3);
    chk("bp_rdy_back", req_ready, 1);
    for (int i = 1; i < 5; i++) begin
      get($sformatf("bp_r%0d", i), bp_q[i], 1'b0);
    end
    tick();
    chk("bp_idle_busy", busy, 0);

    // ---- reset mid-RUN ----
    push(16'h0600, 16'h0200);
    push(16'h0A00, 16'h0200);
    repeat (10) tick();
    chk("mr_running", div_rst, 0);
    chk("mr_cnt_pre", fifo_count, 1);
    rst = 1'b0;
    #1;
    chk("mr_vld", res_valid, 0);
    chk("mr_cnt", fifo_count, 0);
    chk("mr_divrst", div_rst, 1);
    chk("mr_busy", busy, 0);
    tick();
    rst = 1'b1;
    tick();
    push(16'h0900, 16'h0300);
    get("mr_after", 16'h0300, 1'b0);
    tick();
    chk("mr_idle", busy, 0);

    // ---- divider never completes ----
    stall = 1'b1;
    push(16'h0600, 16'h0200);            // edge N
`ifdef DIV_SCHED_TIMEOUT_EN
    n = 0;
    while (res_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("wd_latency", n, 38);
    chk("wd_q", res_q, 0);
    chk("wd_err", res_err, 1);
    chk("wd_divrst", div_rst, 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("wd_drop", res_valid, 0);
    stall = 1'b0;
`else
    acc = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (res_valid === 1'b1) acc++;
    end
    chk("nowd_vld", acc, 0);
    chk("nowd_running", div_rst, 0);
    chk("nowd_busy", busy, 1);
    stall = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
`endif
    push(16'hFA00, 16'hFC00);            // -6 / -4 = 1.5
    get("final", 16'h0180, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
